// File: rtl/oled_pkg.sv
// Shared OLED constants: panel geometry, RGB565 palette and the pixel-scanner state encoding.
package oled_pkg;

    localparam int unsigned OLED_WIDTH  = 96;
    localparam int unsigned OLED_HEIGHT = 64;
    localparam int unsigned OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

    localparam int unsigned X_W     = 7;
    localparam int unsigned Y_W     = 6;
    localparam int unsigned IDX_W   = 13;
    localparam int unsigned COLOR_W = 16;

    localparam logic [COLOR_W-1:0] BLACK   = 16'h0000;
    localparam logic [COLOR_W-1:0] WHITE   = 16'hFFFF;
    localparam logic [COLOR_W-1:0] RED     = 16'hF800;
    localparam logic [COLOR_W-1:0] GREEN   = 16'h07E0;
    localparam logic [COLOR_W-1:0] BLUE    = 16'h001F;
    localparam logic [COLOR_W-1:0] YELLOW  = 16'hFFE0;
    localparam logic [COLOR_W-1:0] CYAN    = 16'h07FF;
    localparam logic [COLOR_W-1:0] MAGENTA = 16'hF81F;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StPresent,
        StDone
    } scan_state_t;

endpackage

// File: rtl/oled_pixel_scanner_if.sv
// Pixel stream from the scanner to the OLED transmitter (valid/ready handshake).
interface oled_pixel_scanner_if;
    import oled_pkg::*;

    logic [COLOR_W-1:0] pix_data;
    logic [IDX_W-1:0]   pix_index;
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_last;

    modport master (
        output pix_data,
        output pix_index,
        output pix_valid,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_index,
        input  pix_valid,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/pixel_coord_counter.sv
// Row-major (x, y) coordinate counter with linear index; wraps to (0, 0) after the last pixel.
module pixel_coord_counter
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH  = OLED_WIDTH,
    parameter int unsigned HEIGHT = OLED_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic [IDX_W-1:0] o_index,
    output logic             o_last
);

    logic [X_W-1:0]   r_x, w_x_d;
    logic [Y_W-1:0]   r_y, w_y_d;
    logic [IDX_W-1:0] r_index, w_index_d;
    logic             w_x_end;
    logic             w_last;

    assign w_x_end = (r_x == X_W'(WIDTH - 1));
    assign w_last  = w_x_end && (r_y == Y_W'(HEIGHT - 1));

    always_comb begin
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_index_d = r_index;
        if (i_clr || (i_inc && w_last)) begin
            w_x_d     = '0;
            w_y_d     = '0;
            w_index_d = '0;
        end else if (i_inc) begin
            w_index_d = r_index + IDX_W'(1);
            if (w_x_end) begin
                w_x_d = '0;
                w_y_d = r_y + Y_W'(1);
            end else begin
                w_x_d = r_x + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_index <= '0;
        end else begin
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_index <= w_index_d;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_index = r_index;
    assign o_last  = w_last;

endmodule

// File: rtl/oled_pixel_scanner.sv
// Walks the renderer over the panel in row-major order and streams each captured RGB565 pixel
// to the OLED transmitter over a valid/ready handshake.
module oled_pixel_scanner
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH      = OLED_WIDTH,
    parameter int unsigned HEIGHT     = OLED_HEIGHT,
    parameter int unsigned RENDER_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_frame_req,
    input  logic                 i_abort,
    output logic [X_W-1:0]       o_x,
    output logic [Y_W-1:0]       o_y,
    input  logic [COLOR_W-1:0]   i_oled_data,
    oled_pixel_scanner_if.master pix,
    output logic                 o_frame_busy,
    output logic                 o_frame_done
);

    localparam logic [1:0] LAT_LAST = 2'(RENDER_LAT - 1);

    scan_state_t        r_state, w_state_d;
    logic [1:0]         r_lat_cnt, w_lat_d;
    logic [COLOR_W-1:0] r_pix_data;
    logic [IDX_W-1:0]   r_pix_index;
    logic               r_pix_last;
    logic               r_pix_valid, w_valid_d;
    logic               r_frame_busy, w_busy_d;
    logic               r_frame_done, w_done_d;
    logic               w_capture;
    logic               w_last_clr;
    logic               w_clr;
    logic               w_inc;
    logic [IDX_W-1:0]   w_index;
    logic               w_last;

    pixel_coord_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_coord (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_index (w_index),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_d  = r_state;
        w_lat_d    = r_lat_cnt;
        w_valid_d  = r_pix_valid;
        w_busy_d   = r_frame_busy;
        w_done_d   = 1'b0;
        w_capture  = 1'b0;
        w_last_clr = 1'b0;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        // Abort wins over everything, including a handshake in the same cycle.
        if (i_abort) begin
            w_state_d  = StIdle;
            w_lat_d    = '0;
            w_valid_d  = 1'b0;
            w_busy_d   = 1'b0;
            w_last_clr = 1'b1;
            w_clr      = 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_frame_req) begin
                        w_state_d = StIssue;
                        w_lat_d   = '0;
                        w_busy_d  = 1'b1;
                        w_clr     = 1'b1;
                    end
                end
                StIssue: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        w_capture = 1'b1;
                        w_valid_d = 1'b1;
                        w_state_d = StPresent;
                    end else begin
                        w_lat_d = r_lat_cnt + 2'd1;
                    end
                end
                StPresent: begin
                    if (r_pix_valid && pix.pix_ready) begin
                        w_valid_d = 1'b0;
                        w_lat_d   = '0;
                        w_inc     = 1'b1;
                        if (r_pix_last) begin
                            w_state_d = StDone;
                            w_busy_d  = 1'b0;
                            w_done_d  = 1'b1;
                        end else begin
                            w_state_d = StIssue;
                        end
                    end
                end
                StDone: begin
                    w_state_d = StIdle;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_lat_cnt    <= '0;
            r_pix_data   <= '0;
            r_pix_index  <= '0;
            r_pix_last   <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_lat_cnt    <= w_lat_d;
            r_pix_valid  <= w_valid_d;
            r_frame_busy <= w_busy_d;
            r_frame_done <= w_done_d;
            if (w_capture) begin
                r_pix_data  <= i_oled_data;
                r_pix_index <= w_index;
                r_pix_last  <= w_last;
            end else if (w_last_clr) begin
                r_pix_last <= 1'b0;
            end
        end
    end

    assign pix.pix_data   = r_pix_data;
    assign pix.pix_index  = r_pix_index;
    assign pix.pix_valid  = r_pix_valid;
    assign pix.pix_last   = r_pix_last;
    assign o_frame_busy   = r_frame_busy;
    assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_oled_pixel_scanner.sv
// Directed bench: two scanners (RENDER_LAT 1 and 3) driven by a {x, y, 3'b0} renderer model.
module tb_oled_pixel_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic req   = 1'b0;
    logic abrt  = 1'b0;
    logic sel   = 1'b0;
    logic ready = 1'b0;

    logic [6:0] x_a, x_b;
    logic [5:0] y_a, y_b;
    logic       busy_a, busy_b, done_a, done_b;

    oled_pixel_scanner_if pa ();
    oled_pixel_scanner_if pb ();
    assign pa.pix_ready = ready;
    assign pb.pix_ready = ready;

    oled_pixel_scanner #(.RENDER_LAT(1)) u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .i_frame_req  (req & ~sel),
        .i_abort      (abrt & ~sel),
        .o_x          (x_a),
        .o_y          (y_a),
        .i_oled_data  ({x_a, y_a, 3'b000}),
        .pix          (pa),
        .o_frame_busy (busy_a),
        .o_frame_done (done_a)
    );

    oled_pixel_scanner #(.RENDER_LAT(3)) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .i_frame_req  (req & sel),
        .i_abort      (abrt & sel),
        .o_x          (x_b),
        .o_y          (y_b),
        .i_oled_data  ({x_b, y_b, 3'b000}),
        .pix          (pb),
        .o_frame_busy (busy_b),
        .o_frame_done (done_b)
    );

    logic        m_valid, m_last, m_busy, m_done;
    logic [15:0] m_data;
    logic [12:0] m_index;
    logic [6:0]  m_x;
    logic [5:0]  m_y;
    assign m_valid = sel ? pb.pix_valid : pa.pix_valid;
    assign m_last  = sel ? pb.pix_last  : pa.pix_last;
    assign m_data  = sel ? pb.pix_data  : pa.pix_data;
    assign m_index = sel ? pb.pix_index : pa.pix_index;
    assign m_x     = sel ? x_b : x_a;
    assign m_y     = sel ? y_b : y_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx, n_acc, bad_idx, bad_data, bad_last, bad_stable, bad_gap;
    int done_cnt, first_cyc, prev_cyc, last_acc, done_cyc, quiet_done;
    logic [6:0] wrap_x;
    logic [5:0] wrap_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int idx);
        logic [6:0] mx;
        logic [5:0] my;
        mx = 7'(idx % 96);
        my = 6'(idx / 96);
        return {mx, my, 3'b000};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_busy"},  32'(m_busy),  0);
        check({tag, "_done"},  32'(m_done),  0);
        check({tag, "_last"},  32'(m_last),  0);
        check({tag, "_x"},     32'(m_x),     0);
        check({tag, "_y"},     32'(m_y),     0);
        check({tag, "_index"}, 32'(m_index), 0);
        check({tag, "_data"},  32'(m_data),  0);
    endtask

    // Monitors one frame on the selected DUT; optionally aborts or resets at a given index.
    task automatic scan(input bit rnd, input int abort_at, input int rst_at, input bit poke);
        bit          held, prev_v, prev_r, done_seen;
        logic [15:0] hd;
        logic [12:0] hi;
        int          idx, gap;
        gap = sel ? 4 : 2;
        exp_idx = 0; n_acc = 0; bad_idx = 0; bad_data = 0; bad_last = 0;
        bad_stable = 0; bad_gap = 0; done_cnt = 0;
        first_cyc = -1; prev_cyc = -1; last_acc = -1; done_cyc = -1;
        wrap_x = '1; wrap_y = '1;
        prev_v = 0; prev_r = 0; done_seen = 0; hd = '0; hi = '0;
        for (int c = 0; c < 30000 && !done_seen; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (m_done) begin
                done_cnt++;
                done_cyc  = c;
                done_seen = 1;
                if (poke) req = 1'b1;
            end
            held = m_valid && prev_v && !prev_r;
            if (m_valid) begin
                if (held) begin
                    if (m_data !== hd || m_index !== hi) bad_stable++;
                end else begin
                    idx = exp_idx;
                    if (m_index !== 13'(idx)) bad_idx++;
                    if (m_data !== model(idx)) bad_data++;
                    if (m_x !== 7'(idx % 96) || m_y !== 6'(idx / 96)) bad_data++;
                    if (m_last !== (idx == 6143)) bad_last++;
                    if (!rnd && prev_cyc >= 0 && (c - prev_cyc) != gap) bad_gap++;
                    if (first_cyc < 0) first_cyc = c;
                    prev_cyc = c;
                    if (idx == 96) begin
                        wrap_x = m_x;
                        wrap_y = m_y;
                    end
                    hd = m_data;
                    hi = m_index;
                    if (idx == abort_at) abrt = 1'b1;
                    if (poke && idx == 10) req = 1'b1;
                    if (idx == rst_at) begin
                        #1 rst_b = 1'b1;
                        #1 check_all_zero("async_rst");
                        @(negedge clk);
                        rst_b = 1'b0;
                        return;
                    end
                end
                ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
                if (abrt) ready = 1'b1;
                if (ready && !abrt) begin
                    exp_idx++;
                    n_acc++;
                    last_acc = c;
                end
            end else begin
                ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            prev_v = m_valid;
            prev_r = ready;
            if (abrt) begin
                @(negedge clk);
                abrt = 1'b0;
                check("abort_valid", 32'(m_valid), 0);
                check("abort_busy",  32'(m_busy),  0);
                check("abort_last",  32'(m_last),  0);
                check("abort_done",  32'(m_done),  0);
                check("abort_xy",    32'({m_x, m_y}), 0);
                return;
            end
        end
        check("frame_completed", 32'(done_seen), 1);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic quiet(input int n);
        quiet_done = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_done || m_valid || m_busy) quiet_done++;
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        req = 1'b1;
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("post_reset_valid", 32'(m_valid), 0);

        // Full frame, ready high, frame_req poked during PRESENT and DONE.
        sel = 1'b0;
        pulse_req();
        scan(1'b0, -1, -1, 1'b1);
        check("t1_first_latency", 32'(first_cyc), 1);
        check("t1_accepted", 32'(n_acc), 6144);
        check("t1_bad_index", 32'(bad_idx), 0);
        check("t1_bad_data", 32'(bad_data), 0);
        check("t1_bad_last", 32'(bad_last), 0);
        check("t1_bad_spacing", 32'(bad_gap), 0);
        check("t1_done_pulses", 32'(done_cnt), 1);
        check("t1_done_timing", 32'(done_cyc), 32'(last_acc + 1));
        check("t1_wrap_x", 32'(wrap_x), 0);
        check("t1_wrap_y", 32'(wrap_y), 1);
        quiet(6);
        check("t1_no_second_frame", 32'(quiet_done), 0);

        // Full frame with pseudo-random ready.
        pulse_req();
        scan(1'b1, -1, -1, 1'b0);
        check("t2_accepted", 32'(n_acc), 6144);
        check("t2_bad_index", 32'(bad_idx), 0);
        check("t2_bad_data", 32'(bad_data), 0);
        check("t2_bad_last", 32'(bad_last), 0);
        check("t2_unstable_hold", 32'(bad_stable), 0);
        check("t2_done_pulses", 32'(done_cnt), 1);

        // Abort at pixel 100 during a handshake, then restart from index 0.
        pulse_req();
        scan(1'b0, 100, -1, 1'b0);
        check("t3_accepted", 32'(n_acc), 100);
        quiet(4);
        check("t3_idle_after_abort", 32'(quiet_done), 0);
        pulse_req();
        scan(1'b0, 2, -1, 1'b0);
        check("t4_restart_latency", 32'(first_cyc), 1);
        check("t4_restart_index", 32'(bad_idx), 0);
        check("t4_accepted", 32'(n_acc), 2);

        // RENDER_LAT=3: reset mid-frame at index 3000, then a full frame.
        sel = 1'b1;
        pulse_req();
        scan(1'b0, -1, 3000, 1'b0);
        check("t5_first_latency", 32'(first_cyc), 3);
        check("t5_accepted_before_rst", 32'(n_acc), 3000);
        check("t5_bad_spacing", 32'(bad_gap), 0);
        check("t5_no_done", 32'(done_cnt), 0);
        pulse_req();
        scan(1'b0, -1, -1, 1'b0);
        check("t6_accepted", 32'(n_acc), 6144);
        check("t6_bad_index", 32'(bad_idx), 0);
        check("t6_bad_data", 32'(bad_data), 0);
        check("t6_bad_spacing", 32'(bad_gap), 0);
        check("t6_done_pulses", 32'(done_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
